// File: rtl/mips_ctrl_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard controller.
// Optional feature macro used by the controller: HAZ_PERF_CNT_EN.
package mips_ctrl_pkg;

    // Controller FSM: normal flow, or frozen waiting on data memory.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    // Register $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bits needed to count from 0 up to timeout-1.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mips_pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline registers and the hazard controller.
// master = pipeline/datapath side, slave = hazard controller.
//
// Data-memory handshake: mem_req is held high for as long as an access is
// outstanding; the access completes in the cycle where mem_req and mem_ready
// are both high. mem_ready is ignored while mem_req is low, and a request is
// never withdrawn before completion except by reset or timeout.
interface mips_pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import mips_ctrl_pkg::*;

    // hazard sources from the pipeline
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic             branch_taken;
    logic             exmem_memrd;
    logic             exmem_memwr;
    logic             mem_ready;

    // controls back to the pipeline
    logic             mem_req;
    logic             pc_ld;
    logic             ifid_ld;
    logic             idex_ld;
    logic             exmem_ld;
    logic             memwb_ld;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    state_e           dbg_state;

    modport master (
        output ifid_rs, ifid_rt, idex_memread, idex_rt, branch_taken,
               exmem_memrd, exmem_memwr, mem_ready,
        input  mem_req, pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld,
               ifid_flush, idex_flush, memwb_flush, mem_err,
               stall_cnt, flush_cnt, dbg_state
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_memread, idex_rt, branch_taken,
               exmem_memrd, exmem_memwr, mem_ready,
        output mem_req, pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld,
               ifid_flush, idex_flush, memwb_flush, mem_err,
               stall_cnt, flush_cnt, dbg_state
    );

endinterface

// File: rtl/mips_load_use_detect.sv
// Combinational load-use hazard compare: a load in EX whose destination is
// read by the instruction in ID.
module mips_load_use_detect
    import mips_ctrl_pkg::*;
(
    input  logic       i_idex_memread,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    output logic       o_load_use
);

    logic w_dest_live;
    logic w_src_match;

    assign w_dest_live = i_idex_memread && (i_idex_rt != REG_ZERO);
    assign w_src_match = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
    assign o_load_use  = w_dest_live && w_src_match;

endmodule

// File: rtl/mips_pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Priority: memory freeze > load-use bubble > taken-branch flush.
// Optional performance counters enabled by defining HAZ_PERF_CNT_EN.
module mips_pipe_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
)(
    input logic                     i_clk,
    input logic                     i_rst,
    mips_pipe_hazard_ctrl_if.slave  hz
);

    localparam int             WCW       = wait_cnt_width(MEM_TIMEOUT);
    localparam logic [WCW-1:0] LAST_WAIT = WCW'(MEM_TIMEOUT - 1);

    state_e         r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_mem_err;

    logic w_mem_acc;
    logic w_timeout;
    logic w_frozen;
    logic w_load_use;
    logic w_mem_req;
    logic w_pc_ld, w_ifid_ld, w_idex_ld, w_exmem_ld, w_memwb_ld;
    logic w_ifid_flush, w_idex_flush, w_memwb_flush;

    mips_load_use_detect u_lu (
        .i_idex_memread (hz.idex_memread),
        .i_idex_rt      (hz.idex_rt),
        .i_ifid_rs      (hz.ifid_rs),
        .i_ifid_rt      (hz.ifid_rt),
        .o_load_use     (w_load_use)
    );

    assign w_mem_acc = hz.exmem_memrd | hz.exmem_memwr;
    // Last permitted wait cycle: release the datapath as if the memory answered.
    assign w_timeout = (r_state == MEM_WAIT) && (r_wait_cnt == LAST_WAIT);
    // The first cycle of a slow access already freezes, before MEM_WAIT is entered.
    assign w_frozen  = (r_state == RUN) ? (w_mem_acc && !hz.mem_ready)
                                        : !(hz.mem_ready || w_timeout);

    // Prioritised load enables and flushes, all forced low during reset.
    always_comb begin
        w_mem_req     = 1'b0;
        w_pc_ld       = 1'b0;
        w_ifid_ld     = 1'b0;
        w_idex_ld     = 1'b0;
        w_exmem_ld    = 1'b0;
        w_memwb_ld    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_memwb_flush = 1'b0;
        if (i_rst) begin
            w_mem_req = (r_state == MEM_WAIT) ? 1'b1 : w_mem_acc;
            if (w_frozen) begin
                // MEM frozen: let WB drain a bubble so results are not written twice.
                w_memwb_ld    = 1'b1;
                w_memwb_flush = 1'b1;
            end else if (w_load_use) begin
                w_idex_ld    = 1'b1;
                w_exmem_ld   = 1'b1;
                w_memwb_ld   = 1'b1;
                w_idex_flush = 1'b1;
            end else begin
                w_pc_ld      = 1'b1;
                w_ifid_ld    = 1'b1;
                w_idex_ld    = 1'b1;
                w_exmem_ld   = 1'b1;
                w_memwb_ld   = 1'b1;
                w_ifid_flush = hz.branch_taken;
            end
        end
    end

    // Memory-wait FSM with saturating wait counter and timeout error pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_mem_acc && !hz.mem_ready) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hz.mem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                        r_mem_err  <= 1'b1;
                    end else if (r_wait_cnt != LAST_WAIT) begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Free-running stall and flush event counters, wrapping naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_ld)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_ifid_flush || w_idex_flush || w_memwb_flush)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

    assign hz.mem_req     = w_mem_req;
    assign hz.pc_ld       = w_pc_ld;
    assign hz.ifid_ld     = w_ifid_ld;
    assign hz.idex_ld     = w_idex_ld;
    assign hz.exmem_ld    = w_exmem_ld;
    assign hz.memwb_ld    = w_memwb_ld;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_flush  = w_idex_flush;
    assign hz.memwb_flush = w_memwb_flush;
    assign hz.mem_err     = r_mem_err;
    assign hz.dbg_state   = r_state;

endmodule

// File: tb/tb_mips_pipe_hazard_ctrl.sv
// Self-checking bench for mips_pipe_hazard_ctrl (MEM_TIMEOUT set to 4).
module tb_mips_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    mips_pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    mips_pipe_hazard_ctrl #(
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .hz    (hz)
    );

    int total = 0;
    int bad   = 0;

    // reference model state: cycles the current access has been outstanding
    int               m_wait  = 0;
    logic             m_err   = 1'b0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    // observed event tallies for scenario-level checks
    int obs_stall = 0;
    int obs_err   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic ld, input logic [4:0] ldrt, input logic br,
                         input logic rd, input logic wr, input logic rdy);
        hz.ifid_rs      = rs;
        hz.ifid_rt      = rt;
        hz.idex_memread = ld;
        hz.idex_rt      = ldrt;
        hz.branch_taken = br;
        hz.exmem_memrd  = rd;
        hz.exmem_memwr  = wr;
        hz.mem_ready    = rdy;
    endtask

    // one clock: check outputs mid-cycle against the model, then advance the model
    task automatic step(input string tag);
        logic       acc, waiting, expired, frozen, lu;
        logic [9:0] exp_v, obs_v;
        logic       e_req, e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fi, e_fd, e_fw;
        @(negedge clk);
        acc     = hz.exmem_memrd | hz.exmem_memwr;
        waiting = (m_wait > 0);
        expired = waiting && (m_wait == TIMEOUT - 1);
        frozen  = (waiting || acc) && !hz.mem_ready && !expired;
        lu      = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                  ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));
        {e_req, e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fi, e_fd, e_fw} = '0;
        if (rst_n) begin
            e_req = waiting || acc;
            if (frozen) begin
                e_memwb = 1'b1;
                e_fw    = 1'b1;
            end else if (lu) begin
                {e_idex, e_exmem, e_memwb, e_fd} = 4'b1111;
            end else begin
                {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
                e_fi = hz.branch_taken;
            end
        end
        exp_v = {e_req, e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fi, e_fd, e_fw, m_err};
        obs_v = {hz.mem_req, hz.pc_ld, hz.ifid_ld, hz.idex_ld, hz.exmem_ld, hz.memwb_ld,
                 hz.ifid_flush, hz.idex_flush, hz.memwb_flush, hz.mem_err};
        check({tag, " ctl"}, 32'(obs_v), 32'(exp_v));
`ifdef HAZ_PERF_CNT_EN
        check({tag, " stall_cnt"}, hz.stall_cnt, m_stall);
        check({tag, " flush_cnt"}, hz.flush_cnt, m_flush);
`else
        check({tag, " stall_cnt"}, hz.stall_cnt, 32'd0);
        check({tag, " flush_cnt"}, hz.flush_cnt, 32'd0);
`endif
        if (hz.pc_ld === 1'b0) obs_stall++;
        if (hz.mem_err === 1'b1) obs_err++;
        @(posedge clk);
        if (!rst_n) begin
            m_wait  = 0;
            m_err   = 1'b0;
            m_stall = '0;
            m_flush = '0;
        end else begin
            m_err  = expired && !hz.mem_ready;
            m_wait = frozen ? m_wait + 1 : 0;
            if (!e_pc) m_stall = m_stall + 1;
            if (e_fi || e_fd || e_fw) m_flush = m_flush + 1;
        end
        #1;
    endtask

    initial begin
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset holds everything off, release enables all loads
        step("t1 rst0");
        step("t1 rst1");
        rst_n = 1'b1;
        step("t1 run");

        // 2: load-use bubble, then the bubble clears; $zero never stalls
        drive(5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        obs_stall = 0;
        step("t2 lu");
        drive(5'd8, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2 bubble");
        check("t2 stall cycles", obs_stall, 1);
        drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2 zero");

        // 3: load with ready three cycles later
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        obs_stall = 0;
        for (int i = 0; i < 3; i++) step("t3 wait");
        hz.mem_ready = 1'b1;
        step("t3 ready");
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3 after");
        check("t3 stall cycles", obs_stall, 3);

        // 4: zero-wait store
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        obs_stall = 0;
        step("t4 store");
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4 after");
        check("t4 stall cycles", obs_stall, 0);

        // 5: memory never answers, timeout releases and pulses mem_err once
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        obs_stall = 0;
        obs_err   = 0;
        for (int i = 0; i < TIMEOUT; i++) step("t5 wait");
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5 err");
        step("t5 idle");
        check("t5 stall cycles", obs_stall, TIMEOUT - 1);
        check("t5 err pulses", obs_err, 1);

        // 6: freeze, then load-use, then branch flush
        drive(5'd4, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        step("t6 freeze");
        hz.mem_ready = 1'b1;
        step("t6 lu");
        drive(5'd4, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t6 branch");

        // 7: mid-wait reset abandons access without an error
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        obs_err = 0;
        step("t7 wait");
        step("t7 wait");
        rst_n = 1'b0;
        step("t7 rst");
        rst_n = 1'b1;
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t7 run");
        step("t7 run");
        check("t7 err pulses", obs_err, 0);

        // 8: randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
